multi_operand_adder_pipe: RTL and testbench

//   Parametrised, pipelined sum of NUM_OPS operands of WIDTH bits each.

---
 rtl/multi_operand_adder_pipe_if.sv | 27 ++
 rtl/multi_operand_adder_pipe.sv | 124 ++++++++++++
 tb/tb_multi_operand_adder_pipe.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_operand_adder_pipe_if.sv
// Handshake bundle for multi_operand_adder_pipe: input operand stream and
// output sum stream, each with its own valid/ready pair.
interface multi_operand_adder_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 3
) ();
  localparam int OUT_W = WIDTH + $clog2(NUM_OPS);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OPS*WIDTH-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_sum;
  logic                     out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_last
  );
endinterface

// File: rtl/multi_operand_adder_pipe.sv
// Pipelined full-precision sum of NUM_OPS operands, built as a balanced
// binary adder tree whose levels are spread across PIPE_STAGES registers.
module multi_operand_adder_pipe #(
  parameter int WIDTH       = 8,
  parameter int NUM_OPS     = 3,
  parameter int PIPE_STAGES = 2,
  parameter int SIGNED      = 0
) (
  input logic                       clk,
  input logic                       reset,
  multi_operand_adder_pipe_if.slave bus
);
  localparam int OUT_W    = WIDTH + $clog2(NUM_OPS);
  localparam int TREE_D   = $clog2(NUM_OPS);
  localparam int LVL_BASE = TREE_D / PIPE_STAGES;
  localparam int LVL_REM  = TREE_D % PIPE_STAGES;

  // Partial sums live in a fixed NUM_OPS-wide vector; unused slots stay zero.
  typedef logic [NUM_OPS-1:0][OUT_W-1:0] ops_t;

  function automatic ops_t tree_level(input ops_t a);
    logic [2*NUM_OPS-1:0][OUT_W-1:0] p;
    ops_t r;
    p = '0;
    p[NUM_OPS-1:0] = a;
    r = '0;
    for (int j = 0; j < NUM_OPS; j++) begin
      r[j] = p[2*j] + p[2*j+1];
    end
    return r;
  endfunction

  function automatic ops_t reduce_levels(input ops_t a, input int n);
    ops_t r;
    r = a;
    for (int l = 0; l < TREE_D; l++) begin
      if (l < n) r = tree_level(r);
    end
    return r;
  endfunction

  // Remainder tree levels land in the earliest stages.
  function automatic int lvl_count(input int s);
    return LVL_BASE + ((s < LVL_REM) ? 1 : 0);
  endfunction

  ops_t                   w_ext;
  ops_t                   w_res    [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] w_up_valid;
  logic [PIPE_STAGES-1:0] w_up_last;
  logic [PIPE_STAGES-1:0] w_adv;
  ops_t                   r_data   [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_valid;
  logic [PIPE_STAGES-1:0] r_last;
  logic                   w_unused;

  always_comb begin
    w_ext = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (SIGNED != 0) w_ext[k] = OUT_W'($signed(bus.in_data[k*WIDTH +: WIDTH]));
      else             w_ext[k] = OUT_W'(bus.in_data[k*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    ops_t src;
    src        = '0;
    w_res      = '{default: '0};
    w_up_valid = '0;
    w_up_last  = '0;
    for (int s = 0; s < PIPE_STAGES; s++) begin
      if (s == 0) begin
        src           = w_ext;
        w_up_valid[s] = bus.in_valid;
        w_up_last[s]  = bus.in_last;
      end else begin
        src           = r_data[(s == 0) ? 0 : s-1];
        w_up_valid[s] = r_valid[(s == 0) ? 0 : s-1];
        w_up_last[s]  = r_last[(s == 0) ? 0 : s-1];
      end
      w_res[s] = reduce_levels(src, lvl_count(s));
    end
  end

  // Handshake: a beat moves on any edge where valid & ready are both high.
  // A stage may load when empty or when the stage after it is also moving,
  // so an empty stage always fills even while the output is stalled; the
  // resulting ready chain is purely combinational from out_ready to in_ready.
  always_comb begin
    logic carry;
    carry = bus.out_ready;
    w_adv = '0;
    for (int s = PIPE_STAGES-1; s >= 0; s--) begin
      carry    = !r_valid[s] | carry;
      w_adv[s] = carry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_last  <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) r_data[s] <= '0;
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (w_adv[s]) begin
          r_valid[s] <= w_up_valid[s];
          if (w_up_valid[s]) begin
            r_data[s] <= w_res[s];
            r_last[s] <= w_up_last[s];
          end
        end
      end
    end
  end

  assign bus.in_ready  = w_adv[0];
  assign bus.out_valid = r_valid[PIPE_STAGES-1];
  assign bus.out_sum   = r_data[PIPE_STAGES-1][0];
  assign bus.out_last  = r_last[PIPE_STAGES-1];

  // Upper slots of the final stage are always zero once the tree has fully reduced.
  assign w_unused = ^r_data[PIPE_STAGES-1][NUM_OPS-1:1];
endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Directed and scoreboard-checked bench for multi_operand_adder_pipe across
// unsigned, signed and deeper-pipeline configurations.
module tb_multi_operand_adder_pipe;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic stop_rand = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_operand_adder_pipe_if #(.WIDTH(8), .NUM_OPS(3)) if_a ();
  multi_operand_adder_pipe_if #(.WIDTH(8), .NUM_OPS(3)) if_s ();
  multi_operand_adder_pipe_if #(.WIDTH(4), .NUM_OPS(5)) if_c ();

  multi_operand_adder_pipe #(.WIDTH(8), .NUM_OPS(3), .PIPE_STAGES(2), .SIGNED(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  multi_operand_adder_pipe #(.WIDTH(8), .NUM_OPS(3), .PIPE_STAGES(2), .SIGNED(1))
    dut_s (.clk(clk), .reset(reset), .bus(if_s.slave));
  multi_operand_adder_pipe #(.WIDTH(4), .NUM_OPS(5), .PIPE_STAGES(3), .SIGNED(0))
    dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  // Expected entries are {last, sum}.
  logic [10:0] exp_a_q[$];
  logic [10:0] exp_s_q[$];
  logic [7:0]  exp_c_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [10:0] e;
    if (!reset && if_a.out_valid && if_a.out_ready) begin
      if (exp_a_q.size() == 0) check("a_unexpected_out", 32'(exp_a_q.size()), 32'd1);
      else begin
        e = exp_a_q.pop_front();
        check("a_sum", 32'(if_a.out_sum), 32'(e[9:0]));
        check("a_last", 32'(if_a.out_last), 32'(e[10]));
      end
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (!reset && if_s.out_valid && if_s.out_ready) begin
      if (exp_s_q.size() == 0) check("s_unexpected_out", 32'(exp_s_q.size()), 32'd1);
      else begin
        e = exp_s_q.pop_front();
        check("s_sum", 32'(if_s.out_sum), 32'(e[9:0]));
        check("s_last", 32'(if_s.out_last), 32'(e[10]));
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset && if_c.out_valid && if_c.out_ready) begin
      if (exp_c_q.size() == 0) check("c_unexpected_out", 32'(exp_c_q.size()), 32'd1);
      else begin
        e = exp_c_q.pop_front();
        check("c_sum", 32'(if_c.out_sum), 32'(e[6:0]));
        check("c_last", 32'(if_c.out_last), 32'(e[7]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [7:0] o0, o1, o2, input logic last, input logic [9:0] exp);
    int t;
    if_a.in_data  = {o2, o1, o0};
    if_a.in_last  = last;
    if_a.in_valid = 1'b1;
    exp_a_q.push_back({last, exp});
    t = 0;
    @(negedge clk);
    while (!if_a.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("a_accept", 32'(if_a.in_ready), 32'd1);
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] o0, o1, o2, input logic last, input logic [9:0] exp);
    int t;
    if_s.in_data  = {o2, o1, o0};
    if_s.in_last  = last;
    if_s.in_valid = 1'b1;
    exp_s_q.push_back({last, exp});
    t = 0;
    @(negedge clk);
    while (!if_s.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("s_accept", 32'(if_s.in_ready), 32'd1);
    @(posedge clk);
    #1;
    if_s.in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [19:0] data, input logic last, input logic [6:0] exp);
    int t;
    if_c.in_data  = data;
    if_c.in_last  = last;
    if_c.in_valid = 1'b1;
    exp_c_q.push_back({last, exp});
    t = 0;
    @(negedge clk);
    while (!if_c.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("c_accept", 32'(if_c.in_ready), 32'd1);
    @(posedge clk);
    #1;
    if_c.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_a_q.size() + exp_s_q.size() + exp_c_q.size()) != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", 32'(exp_a_q.size() + exp_s_q.size() + exp_c_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    logic [19:0] d;
    int sum;
    int op;

    reset = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_last = 1'b0; if_a.out_ready = 1'b1;
    if_s.in_valid = 1'b0; if_s.in_data = '0; if_s.in_last = 1'b0; if_s.out_ready = 1'b1;
    if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.in_last = 1'b0; if_c.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_out_valid", 32'(if_a.out_valid), 32'd0);
    check("rst_a_in_ready", 32'(if_a.in_ready), 32'd1);
    check("rst_a_out_sum", 32'(if_a.out_sum), 32'd0);
    check("rst_a_out_last", 32'(if_a.out_last), 32'd0);
    check("rst_s_out_valid", 32'(if_s.out_valid), 32'd0);
    check("rst_c_out_valid", 32'(if_c.out_valid), 32'd0);
    check("rst_c_in_ready", 32'(if_c.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 255+255+255 = 765, valid two cycles after the transfer cycle
    send_a(8'd255, 8'd255, 8'd255, 1'b1, 10'h2FD);
    check("a_lat_cycle1", 32'(if_a.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("a_lat_cycle2", 32'(if_a.out_valid), 32'd1);
    check("a_lat_sum", 32'(if_a.out_sum), 32'h2FD);
    drain();

    // Signed operands
    send_s(8'h80, 8'h80, 8'h80, 1'b0, 10'h280);
    send_s(8'h7F, 8'h01, 8'hFF, 1'b1, 10'h07F);
    send_s(8'hFF, 8'hFF, 8'h02, 1'b0, 10'h000);
    drain();

    // Backpressure: four back-to-back inputs with the output stalled 3 cycles
    if_a.out_ready = 1'b0;
    fork
      begin
        send_a(8'd1, 8'd2, 8'd3, 1'b0, 10'd6);
        send_a(8'd4, 8'd5, 8'd6, 1'b1, 10'd15);
        send_a(8'd7, 8'd8, 8'd9, 1'b0, 10'd24);
        send_a(8'd10, 8'd11, 8'd12, 1'b1, 10'd33);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("bp_in_ready_full", 32'(if_a.in_ready), 32'd0);
        check("bp_out_valid", 32'(if_a.out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("bp_hold_sum", 32'(if_a.out_sum), 32'd6);
        check("bp_hold_last", 32'(if_a.out_last), 32'd0);
        if_a.out_ready = 1'b1;
      end
    join
    drain();

    // Bubble collapse: stalled output, empty first stage still accepts
    if_a.out_ready = 1'b0;
    send_a(8'd10, 8'd20, 8'd30, 1'b1, 10'd60);
    @(posedge clk);
    #1;
    check("bub_out_valid", 32'(if_a.out_valid), 32'd1);
    check("bub_in_ready", 32'(if_a.in_ready), 32'd1);
    send_a(8'd40, 8'd50, 8'd60, 1'b0, 10'd150);
    check("bub_in_ready_full", 32'(if_a.in_ready), 32'd0);
    check("bub_hold_sum", 32'(if_a.out_sum), 32'd60);
    if_a.out_ready = 1'b1;
    drain();

    // Reset with two transactions in flight
    if_a.out_ready = 1'b0;
    send_a(8'd1, 8'd1, 8'd1, 1'b1, 10'd3);
    send_a(8'd2, 8'd2, 8'd2, 1'b1, 10'd6);
    check("mid_out_valid", 32'(if_a.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    exp_a_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(if_a.out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(if_a.out_sum), 32'd0);
    check("mid_rst_in_ready", 32'(if_a.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    if_a.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("no_stale_out", 32'(if_a.out_valid), 32'd0);
    end

    // W=4, N=5, P=3: 15 x 5 = 75 after three cycles
    send_c(20'hFFFFF, 1'b1, 7'd75);
    check("c_lat_cycle1", 32'(if_c.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("c_lat_cycle2", 32'(if_c.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("c_lat_cycle3", 32'(if_c.out_valid), 32'd1);
    check("c_lat_sum", 32'(if_c.out_sum), 32'd75);
    send_c(20'h54321, 1'b0, 7'd15);
    send_c(20'hF000F, 1'b1, 7'd30);
    drain();

    // Full-rate random traffic: one accept per cycle
    c0 = cyc;
    for (int n = 0; n < 10; n++) begin
      sum = 0;
      for (int k = 0; k < 5; k++) begin
        op = int'($urandom_range(0, 15));
        d[k*4 +: 4] = op[3:0];
        sum += op;
      end
      send_c(d, 1'($urandom_range(0, 1)), 7'(sum));
    end
    check("c_full_rate_cycles", 32'(cyc - c0), 32'd10);
    drain();

    // Randomly stalled traffic
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          sum = 0;
          for (int k = 0; k < 5; k++) begin
            op = int'($urandom_range(0, 15));
            d[k*4 +: 4] = op[3:0];
            sum += op;
          end
          send_c(d, 1'($urandom_range(0, 1)), 7'(sum));
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #1;
          if_c.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    if_c.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
